// File: rtl/uart_pkg.sv
// Shared byte width, line-ending constants and sequencer state encoding
// for the UART transmit FIFO.
package uart_pkg;

  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] LF = 8'h0A;
  localparam logic [BYTE_W-1:0] CR = 8'h0D;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Byte-wide synchronous FIFO with registered occupancy flags and a
// combinational read port showing the head entry.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [BYTE_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_wr;
  logic              do_rd;
  logic [ADDR_W:0]   count_next;

  // A write while full is dropped even when a read frees a slot this cycle.
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_wr && !do_rd) begin
      count_next = count + 1'b1;
    end else if (do_rd && !do_wr) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      full  <= (count_next == DEPTH_CNT);
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffers host bytes and hands them one at a time to the UART transmitter.
// Define UART_TX_FIFO_CRLF_EN to expand each stored LF into CR LF on the wire.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              wr_en,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_send,
  input  logic              tx_busy
);

  tx_state_t         state;
  tx_state_t         state_next;
  logic [BYTE_W-1:0] head;
  logic [BYTE_W-1:0] tx_data_next;
  logic              tx_send_next;
  logic              pop;
`ifdef UART_TX_FIFO_CRLF_EN
  logic              cr_sent;
  logic              cr_sent_next;
`endif

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // WAIT_BUSY covers the cycle before the transmitter raises busy, so a
  // second send can never slip in while busy still reads low.
  always_comb begin
    state_next   = state;
    tx_data_next = tx_data;
    tx_send_next = 1'b0;
    pop          = 1'b0;
`ifdef UART_TX_FIFO_CRLF_EN
    cr_sent_next = cr_sent;
`endif
    case (state)
      IDLE: begin
        if (!empty && !tx_busy) begin
          tx_send_next = 1'b1;
          state_next   = SEND;
`ifdef UART_TX_FIFO_CRLF_EN
          if (head == LF && !cr_sent) begin
            tx_data_next = CR;
            cr_sent_next = 1'b1;
          end else begin
            tx_data_next = head;
            pop          = 1'b1;
            cr_sent_next = 1'b0;
          end
`else
          tx_data_next = head;
          pop          = 1'b1;
`endif
        end
      end
      SEND:      state_next = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy) state_next = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx_data  <= '0;
      tx_send  <= 1'b0;
      overflow <= 1'b0;
`ifdef UART_TX_FIFO_CRLF_EN
      cr_sent  <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      tx_data  <= tx_data_next;
      tx_send  <= tx_send_next;
      overflow <= overflow | (wr_en & full);
`ifdef UART_TX_FIFO_CRLF_EN
      cr_sent  <= cr_sent_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo with a serialising transmitter/receiver
// model (4 clocks per bit); honours UART_TX_FIFO_CRLF_EN in its expectations.
module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic [7:0]        wr_data   = 8'h00;
  logic              wr_en     = 1'b0;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic [7:0]        tx_data;
  logic              tx_send;
  logic              tx_busy;
  logic              model_busy = 1'b0;
  logic              busy_hold  = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] wire_q[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic        wr_en;
    logic [7:0]  wr_data;
    logic [4:0]  exp_count;
    logic        exp_full;
    logic        exp_empty;
    logic        exp_overflow;
  } vec_t;

  vec_t vecs[18];

  always #5 clk = ~clk;

  assign tx_busy = model_busy | busy_hold;

  uart_tx_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_data  (tx_data),
    .tx_send  (tx_send),
    .tx_busy  (tx_busy)
  );

  // Transmitter model: busy rises the cycle after a sampled send, frame is
  // start + 8 data bits LSB first + stop, four clocks per bit.
  logic [9:0] frame   = '1;
  logic [3:0] bit_idx = 4'd0;
  logic [1:0] tick    = 2'd0;
  logic       line    = 1'b1;
  logic [9:0] rx_bits = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      model_busy <= 1'b0;
      line       <= 1'b1;
    end else if (!model_busy) begin
      if (tx_send) begin
        model_busy <= 1'b1;
        frame      <= {1'b1, tx_data, 1'b0};
        bit_idx    <= 4'd0;
        tick       <= 2'd0;
        line       <= 1'b0;
      end
    end else if (tick == 2'd3) begin
      tick <= 2'd0;
      if (bit_idx == 4'd9) begin
        model_busy <= 1'b0;
        line       <= 1'b1;
      end else begin
        bit_idx <= bit_idx + 4'd1;
        line    <= frame[bit_idx + 4'd1];
      end
    end else begin
      tick <= tick + 2'd1;
    end
  end

  // Line receiver samples mid-bit and queues each byte with a valid stop bit.
  always @(posedge clk) begin
    if (rst_n && model_busy && tick == 2'd1) begin
      rx_bits[bit_idx] <= line;
      if (bit_idx == 4'd9 && line) begin
        wire_q.push_back(rx_bits[8:1]);
      end
    end
  end

  int         send_count = 0;
  int         violations = 0;
  int         dec_count  = 0;
  logic       prev_send  = 1'b0;
  logic [4:0] prev_count = '0;

  // Sends must be single-cycle and never issued while the transmitter is busy.
  always @(negedge clk) begin
    if (rst_n && tx_send) begin
      send_count++;
      if (tx_busy || prev_send) violations++;
    end
    prev_send = tx_send;
    if (rst_n && count < prev_count) dec_count++;
    prev_count = count;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [7:0] data);
    wr_en   = en;
    wr_data = data;
    @(negedge clk);
  endtask

  task automatic doReset();
    wr_en     = 1'b0;
    busy_hold = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wire_q.delete();
  endtask

  task automatic checkWire(input string name);
    int cyc = 0;
    while (wire_q.size() < exp_q.size() && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (60) @(negedge clk);
    checkOutput({name, "_len"}, 32'(wire_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      checkOutput({name, "_byte"},
                  (i < wire_q.size()) ? 32'(wire_q[i]) : 32'hDEAD,
                  32'(exp_q[i]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s0;

    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{1'b1, 8'(i), 5'(i + 1), (i == 15), 1'b0, 1'b0};
    end
    vecs[16] = '{1'b1, 8'hFF, 5'd16, 1'b1, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 8'h00, 5'd16, 1'b1, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    checkOutput("rst_full",     32'(full),     32'd0);
    checkOutput("rst_empty",    32'(empty),    32'd1);
    checkOutput("rst_count",    32'(count),    32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_tx_data",  32'(tx_data),  32'h00);
    checkOutput("rst_tx_send",  32'(tx_send),  32'd0);

    // Single byte into an idle FIFO.
    s0 = send_count;
    applyStimulus(1'b1, 8'h41);
    checkOutput("single_count_e",  32'(count),   32'd1);
    checkOutput("single_send_e",   32'(tx_send), 32'd0);
    applyStimulus(1'b0, 8'h00);
    checkOutput("single_send_e1",  32'(tx_send), 32'd1);
    checkOutput("single_data_e1",  32'(tx_data), 32'h41);
    checkOutput("single_count_e1", 32'(count),   32'd0);
    applyStimulus(1'b0, 8'h00);
    checkOutput("single_send_e2",  32'(tx_send), 32'd0);
    exp_q = '{8'h41};
    checkWire("single");
    checkOutput("single_sends", 32'(send_count - s0), 32'd1);

    // Three back-to-back bytes.
    wire_q.delete();
    applyStimulus(1'b1, 8'h31);
    applyStimulus(1'b1, 8'h32);
    applyStimulus(1'b1, 8'h33);
    applyStimulus(1'b0, 8'h00);
    exp_q = '{8'h31, 8'h32, 8'h33};
    checkWire("b2b");
    checkOutput("b2b_empty",      32'(empty),      32'd1);
    checkOutput("b2b_violations", 32'(violations), 32'd0);

    // Fill to full with the transmitter held busy, then overflow.
    wire_q.delete();
    busy_hold = 1'b1;
    for (int v = 0; v < 18; v++) begin
      applyStimulus(vecs[v].wr_en, vecs[v].wr_data);
      checkOutput("fill_count",    32'(count),    32'(vecs[v].exp_count));
      checkOutput("fill_full",     32'(full),     32'(vecs[v].exp_full));
      checkOutput("fill_empty",    32'(empty),    32'(vecs[v].exp_empty));
      checkOutput("fill_overflow", 32'(overflow), 32'(vecs[v].exp_overflow));
    end
    busy_hold = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
`ifdef UART_TX_FIFO_CRLF_EN
      if (i == 10) exp_q.push_back(8'h0D);
`endif
      exp_q.push_back(8'(i));
    end
    checkWire("fill");
    checkOutput("fill_overflow_sticky", 32'(overflow), 32'd1);

    // Write while full in the same cycle as a pop: write is dropped.
    doReset();
    busy_hold = 1'b1;
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'h50 + 8'(i));
    applyStimulus(1'b0, 8'h00);
    checkOutput("fullpop_full_before", 32'(full),     32'd1);
    checkOutput("fullpop_ovf_before",  32'(overflow), 32'd0);
    busy_hold = 1'b0;
    applyStimulus(1'b1, 8'hEE);
    checkOutput("fullpop_count",    32'(count),    32'd15);
    checkOutput("fullpop_overflow", 32'(overflow), 32'd1);
    applyStimulus(1'b0, 8'h00);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h50 + 8'(i));
    checkWire("fullpop");

    // Write and pop together at count 5.
    doReset();
    busy_hold = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'h60 + 8'(i));
    applyStimulus(1'b0, 8'h00);
    checkOutput("midpop_count_before", 32'(count), 32'd5);
    busy_hold = 1'b0;
    applyStimulus(1'b1, 8'h65);
    checkOutput("midpop_count", 32'(count), 32'd5);
    applyStimulus(1'b0, 8'h00);
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(8'h60 + 8'(i));
    checkWire("midpop");
    checkOutput("midpop_overflow", 32'(overflow), 32'd0);

    // Reset while a frame is in flight and four bytes are queued.
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'h70 + 8'(i));
    applyStimulus(1'b0, 8'h00);
    checkOutput("rstmid_busy",  32'(model_busy), 32'd1);
    checkOutput("rstmid_count", 32'(count),      32'd4);
    s0 = send_count;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wire_q.delete();
    checkOutput("rstmid_full",     32'(full),     32'd0);
    checkOutput("rstmid_empty",    32'(empty),    32'd1);
    checkOutput("rstmid_count0",   32'(count),    32'd0);
    checkOutput("rstmid_overflow", 32'(overflow), 32'd0);
    checkOutput("rstmid_tx_data",  32'(tx_data),  32'h00);
    checkOutput("rstmid_tx_send",  32'(tx_send),  32'd0);
    repeat (100) @(negedge clk);
    checkOutput("rstmid_no_send", 32'(send_count - s0), 32'd0);
    checkOutput("rstmid_no_wire", 32'(wire_q.size()),   32'd0);

    // Line-feed handling.
    busy_hold = 1'b1;
    applyStimulus(1'b1, 8'h41);
    applyStimulus(1'b1, 8'h0A);
    applyStimulus(1'b0, 8'h00);
    s0 = dec_count;
    busy_hold = 1'b0;
`ifdef UART_TX_FIFO_CRLF_EN
    exp_q = '{8'h41, 8'h0D, 8'h0A};
`else
    exp_q = '{8'h41, 8'h0A};
`endif
    checkWire("crlf");
    checkOutput("crlf_decrements", 32'(dec_count - s0), 32'd2);
    checkOutput("crlf_empty",      32'(empty),          32'd1);
    checkOutput("final_violations", 32'(violations),    32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer and sequencer directly upstream of the UART transmitter.
- Accepts bytes from the host-side logic (command responder, debug printer) at any rate up to one per clk.
- Stores bytes in a synchronous FIFO and feeds them one at a time to the transmitter's data/send/busy interface, so producers never poll the transmitter.

Parameters:
- DEPTH, 16, number of FIFO entries; power of two, 2..256.
- ADDR_W, 4, log2(DEPTH); must equal clog2(DEPTH).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low; clock clk
- wr_data  in  8  byte to enqueue
- wr_en  in  1  enqueue strobe, one byte per cycle
- full  out  1  FIFO full; a write in this cycle is dropped
- empty  out  1  FIFO empty
- count  out  ADDR_W+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky; set by any write attempted while full
- tx_data  out  8  byte presented to the transmitter
- tx_send  out  1  one-cycle start pulse to the transmitter
- tx_busy  in  1  transmitter busy; rises the cycle after a sampled send and falls after the stop bit

Behaviour:
- Reset values (rst_n=0 at a clk edge):
  - outputs: full=0, empty=1, count=0, overflow=0, tx_data=8'h00, tx_send=0
  - internal: state=IDLE; read and write pointers = 0
  - FIFO contents are not reset.
- Write path:
  - A write with wr_en=1 and full=0 stores wr_data at wr_ptr and increments wr_ptr modulo DEPTH.
  - A write with wr_en=1 and full=1 is dropped and sets overflow. overflow clears only on reset.
  - A write while full is dropped even if a pop occurs in the same cycle.
- Occupancy:
  - count: +1 on write only, -1 on pop only, unchanged on simultaneous write and pop.
  - full = (count==DEPTH); empty = (count==0); both registered and consistent with count.
  - Pointers wrap naturally at DEPTH.
- State machine (registered outputs):
  - IDLE: if !empty and !tx_busy: tx_data <= mem[rd_ptr], pop, tx_send <= 1, go to SEND.
  - SEND: tx_send <= 0, go to WAIT_BUSY. tx_send is high for exactly one cycle.
  - WAIT_BUSY: stay until tx_busy=1, then go to WAIT_DONE. This guards against the one-cycle lag between send and busy; no second send may issue in that window.
  - WAIT_DONE: stay until tx_busy=0, then go to IDLE.
- tx_data is held stable from the SEND cycle until the next pop.
- Latency:
  - A byte written at edge E into an empty FIFO with the transmitter idle gets tx_send=1 after edge E+1.
  - Back-to-back bytes: the next tx_send comes 2 cycles after tx_busy falls (WAIT_DONE->IDLE, then IDLE->SEND).
- Simultaneous write and pop are fully supported at any occupancy except the write-while-full case above.
- Reset mid-frame: the FIFO is flushed and state returns to IDLE; the transmitter is reset by the same rst_n.

Optional Feature:
- Macro: UART_TX_FIFO_CRLF_EN
- Defined:
  - A head byte 8'h0A is expanded on the wire to 8'h0D followed by 8'h0A.
  - In IDLE, a 0x0A head sends 0x0D without popping and sets an internal cr_sent flag.
  - The next IDLE pass sends 0x0A, pops, and clears cr_sent.
  - count and empty reflect stored bytes only. cr_sent clears on reset.
- Undefined: bytes are passed verbatim and no cr_sent logic exists.

Decomposition:
- Package uart_pkg holds:
  - BYTE_W=8
  - LF=8'h0A, CR=8'h0D
  - FSM state encoding for IDLE/SEND/WAIT_BUSY/WAIT_DONE (2 bits)
- One sub-module, sync_fifo (parameters DEPTH, ADDR_W, width 8):
  - ports: wr_en/wr_data, rd_en/rd_data, full/empty/count
  - rd_data is combinational from mem[rd_ptr]
- The top level holds the FSM, overflow, and the optional CRLF logic.

Test Plan:
- Write 8'h41 into an idle, empty FIFO:
  - tx_send is one cycle wide, 2 edges after the write, with tx_data=8'h41.
  - count goes 1->0; no second send until tx_busy rises and falls.
- Write 3 bytes 8'h31, 8'h32, 8'h33 back-to-back with a uart_tx model (CLK_PER_BIT=4):
  - the line decodes "123" in order
  - each tx_send occurs only after tx_busy has fallen
  - empty=1 at the end
- Hold tx_busy=1 and write 16 bytes 8'h00..8'h0F:
  - full=1, count=16
  - a 17th write (8'hFF) sets overflow=1, count stays 16
  - after release, 8'h00..8'h0F are transmitted and 8'hFF is never sent
- At count=16, write and transmitter pop in the same cycle: the write is dropped and overflow=1. At count=5: count stays 5 and the data order is preserved.
- Assert rst_n=0 for one cycle after 4 bytes are queued and one is in flight:
  - outputs take their reset values
  - empty=1
  - no further tx_send occurs
- With UART_TX_FIFO_CRLF_EN defined, write 8'h41, 8'h0A:
  - the wire carries 8'h41, 8'h0D, 8'h0A
  - count decrements only twice
  - undefined build: the wire carries 8'h41, 8'h0A
